xosera_bus_initiator: RTL

- Host-side initiator for the Xosera 8-bit register bus. Drives the bus_cs_n / bus_rd_nwr / bus_reg_num / bus_bytesel / bus_data signals that the Xosera main block receives.
- Converts one 16-bit register command into one or two byte cycles: even byte = data[15:8] first, then odd byte = data[7:0].
- Used by on-FPGA host logic (UART/SPI bridges, self-test sequencers) and as the bus driver in benches.

---
 rtl/xosera_bus_initiator.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/xosera_bus_initiator.sv
// xosera_bus_initiator
//   Host-side initiator for the Xosera 8-bit register bus. A 16-bit register
//   command becomes one or two byte cycles. The even byte (data[15:8]) goes
//   first and the odd byte (data[7:0]) second. An odd-only command runs just
//   the odd-byte cycle.
//
//   State table:
//     IDLE    | waiting for a command; cmd_ready_o high
//     SETUP   | address/data driven, cs_n high
//     STROBE  | cs_n low; read data sampled on the last cycle
//     RECOVER | cs_n high, bus held; then next byte or completion
//
// Ports:
//   clk, reset_i                  clock, synchronous active-high reset
//   cmd_valid_i / cmd_ready_o     command handshake
//   cmd_rd_nwr_i, cmd_reg_num_i,
//   cmd_odd_only_i, cmd_data_i    command fields
//   rsp_valid_o, rsp_data_o       one-cycle completion pulse and read result
//   bus_*_o, bus_data_i           Xosera register bus
//   bus_intr_i, intr_ack_i,
//   intr_pending_o                interrupt latch (build option)
//
// Build option:
//   BUS_INTR_LATCH_EN  when defined, a rising edge on bus_intr_i latches
//                      intr_pending_o until intr_ack_i. Otherwise
//                      intr_pending_o is tied to 0.

module xosera_bus_initiator #(
  parameter int unsigned SETUP_CYCLES   = 1,
  parameter int unsigned STROBE_CYCLES  = 2,
  parameter int unsigned RECOVER_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_rd_nwr_i,
  input  logic [3:0]  cmd_reg_num_i,
  input  logic        cmd_odd_only_i,
  input  logic [15:0] cmd_data_i,
  output logic        rsp_valid_o,
  output logic [15:0] rsp_data_o,
  output logic        bus_cs_n_o,
  output logic        bus_rd_nwr_o,
  output logic [3:0]  bus_reg_num_o,
  output logic        bus_bytesel_o,
  output logic [7:0]  bus_data_o,
  input  logic [7:0]  bus_data_i,
  input  logic        bus_intr_i,
  input  logic        intr_ack_i,
  output logic        intr_pending_o
);

  if (SETUP_CYCLES < 1 || SETUP_CYCLES > 15) begin : g_bad_setup
    $error("SETUP_CYCLES must be in 1..15");
  end
  if (STROBE_CYCLES < 1 || STROBE_CYCLES > 15) begin : g_bad_strobe
    $error("STROBE_CYCLES must be in 1..15");
  end
  if (RECOVER_CYCLES < 1 || RECOVER_CYCLES > 15) begin : g_bad_recover
    $error("RECOVER_CYCLES must be in 1..15");
  end

  // The counter holds N-1 on state entry and the state ends when it reads 0.
  localparam logic [3:0] S_LD = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] T_LD = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] R_LD = 4'(RECOVER_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    STROBE  = 2'd2,
    RECOVER = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        cs_n_q, cs_n_d;
  logic        rd_nwr_q, rd_nwr_d;
  logic [3:0]  reg_num_q, reg_num_d;
  logic        bytesel_q, bytesel_d;
  logic [7:0]  bus_data_q, bus_data_d;
  logic [7:0]  data_lo_q, data_lo_d;   // only the odd byte is needed after accept
  logic [15:0] rd_buf_q, rd_buf_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rsp_data_q, rsp_data_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cs_n_d      = cs_n_q;
    rd_nwr_d    = rd_nwr_q;
    reg_num_d   = reg_num_q;
    bytesel_d   = bytesel_q;
    bus_data_d  = bus_data_q;
    data_lo_d   = data_lo_q;
    rd_buf_d    = rd_buf_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          state_d   = SETUP;
          cnt_d     = S_LD;
          rd_nwr_d  = cmd_rd_nwr_i;
          reg_num_d = cmd_reg_num_i;
          bytesel_d = cmd_odd_only_i;
          data_lo_d = cmd_data_i[7:0];
          // Cleared so an odd-only read returns 0 in the upper byte.
          rd_buf_d  = '0;
          if (cmd_rd_nwr_i)
            bus_data_d = 8'h00;
          else
            bus_data_d = cmd_odd_only_i ? cmd_data_i[7:0] : cmd_data_i[15:8];
        end
      end

      SETUP: begin
        if (cnt_q == 4'd0) begin
          state_d = STROBE;
          cnt_d   = T_LD;
          cs_n_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d = RECOVER;
          cnt_d   = R_LD;
          cs_n_d  = 1'b1;
          if (rd_nwr_q) begin
            if (bytesel_q)
              rd_buf_d[7:0] = bus_data_i;
            else
              rd_buf_d[15:8] = bus_data_i;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      RECOVER: begin
        if (cnt_q == 4'd0) begin
          if (!bytesel_q) begin
            state_d    = SETUP;
            cnt_d      = S_LD;
            bytesel_d  = 1'b1;
            bus_data_d = rd_nwr_q ? 8'h00 : data_lo_q;
          end else begin
            state_d     = IDLE;
            rsp_valid_d = 1'b1;
            rsp_data_d  = rd_nwr_q ? rd_buf_q : 16'h0000;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      default: begin
        state_d = IDLE;
        cs_n_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cs_n_q      <= 1'b1;
      rd_nwr_q    <= 1'b1;
      reg_num_q   <= '0;
      bytesel_q   <= 1'b0;
      bus_data_q  <= '0;
      data_lo_q   <= '0;
      rd_buf_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cs_n_q      <= cs_n_d;
      rd_nwr_q    <= rd_nwr_d;
      reg_num_q   <= reg_num_d;
      bytesel_q   <= bytesel_d;
      bus_data_q  <= bus_data_d;
      data_lo_q   <= data_lo_d;
      rd_buf_q    <= rd_buf_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign cmd_ready_o   = (state_q == IDLE);
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_data_o    = rsp_data_q;
  assign bus_cs_n_o    = cs_n_q;
  assign bus_rd_nwr_o  = rd_nwr_q;
  assign bus_reg_num_o = reg_num_q;
  assign bus_bytesel_o = bytesel_q;
  assign bus_data_o    = bus_data_q;

`ifdef BUS_INTR_LATCH_EN
  logic intr_sync_q, intr_prev_q;
  logic intr_pending_q, intr_pending_d;

  // A new edge in the same cycle as an ack keeps the latch set.
  always_comb begin
    intr_pending_d = intr_pending_q;
    if (intr_ack_i)
      intr_pending_d = 1'b0;
    if (intr_sync_q && !intr_prev_q)
      intr_pending_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      intr_sync_q    <= 1'b0;
      intr_prev_q    <= 1'b0;
      intr_pending_q <= 1'b0;
    end else begin
      intr_sync_q    <= bus_intr_i;
      intr_prev_q    <= intr_sync_q;
      intr_pending_q <= intr_pending_d;
    end
  end

  assign intr_pending_o = intr_pending_q;
`else
  logic unused_intr;
  assign unused_intr    = bus_intr_i ^ intr_ack_i;
  assign intr_pending_o = 1'b0;
`endif

endmodule
